// File: rtl/spi_shifter_if.sv
// Byte-transfer handshake and serial lines of the SPI shifter.
// The master modport is the host plus the selected device; the slave modport is the shifter.
interface spi_shifter_if;
  logic       START;
  logic [7:0] TXD;
  logic       MISO;
  logic       MOSI;
  logic       SCK;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RXD;

  modport master (
    output START, TXD, MISO,
    input  MOSI, SCK, BUSY, DONE, RXD
  );

  modport slave (
    input  START, TXD, MISO,
    output MOSI, SCK, BUSY, DONE, RXD
  );
endinterface

// File: rtl/spi_shifter.sv
// Mode-0 SPI byte shifter: MSB first, SCK half-period of DIV clocks, full duplex.
//
//   state | meaning
//   IDLE  | waiting for START, SCK low, MOSI holds last bit sent
//   LOW   | SCK low for DIV cycles, MOSI shows current bit
//   HIGH  | SCK high for DIV cycles, MISO already sampled on entry
module spi_shifter #(
  parameter int DIV = 2
) (
  input logic         CLK,
  input logic         nRESET,
  spi_shifter_if.slave bus
);

  localparam logic [7:0] PH_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] phase;
  logic [7:0] sr;
  logic [7:0] rxd_q;
  logic       mosi_q;
  logic       done_q;
  logic       phase_end;
  logic       sck;
  logic       busy;

  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.START) state_nxt = LOW;
      LOW:     if (phase_end) state_nxt = HIGH;
      HIGH:    if (phase_end) state_nxt = (bit_cnt == 3'd7) ? IDLE : LOW;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sck  = (state == HIGH);
    busy = (state != IDLE);
  end

  // Datapath: shift register, bit/phase counters and the registered outputs.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sr      <= 8'h00;
      rxd_q   <= 8'h00;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      bit_cnt <= 3'd0;
      phase   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            sr      <= bus.TXD;
            mosi_q  <= bus.TXD[7];
            bit_cnt <= 3'd0;
            phase   <= 8'h00;
          end
        end
        LOW: begin
          if (phase_end) begin
            phase <= 8'h00;
            sr    <= {sr[6:0], bus.MISO};
          end else begin
            phase <= phase + 8'h01;
          end
        end
        HIGH: begin
          if (phase_end) begin
            phase <= 8'h00;
            if (bit_cnt == 3'd7) begin
              done_q <= 1'b1;
              rxd_q  <= sr;
            end else begin
              // sr[7] is already the next bit because the LOW->HIGH edge shifted.
              mosi_q  <= sr[7];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            phase <= phase + 8'h01;
          end
        end
        default: phase <= 8'h00;
      endcase
    end
  end

  assign bus.SCK  = sck;
  assign bus.BUSY = busy;
  assign bus.MOSI = mosi_q;
  assign bus.DONE = done_q;
  assign bus.RXD  = rxd_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Scoreboarded bench for spi_shifter at DIV=1, 2 and 3 with directed transfers.
module tb_spi_shifter;
  logic CLK = 1'b0;
  logic nRESET = 1'b0;

  always #5 CLK = ~CLK;

  spi_shifter_if if1 ();
  spi_shifter_if if2 ();
  spi_shifter_if if3 ();

  spi_shifter #(.DIV(1)) u1 (.CLK(CLK), .nRESET(nRESET), .bus(if1.slave));
  spi_shifter #(.DIV(2)) u2 (.CLK(CLK), .nRESET(nRESET), .bus(if2.slave));
  spi_shifter #(.DIV(3)) u3 (.CLK(CLK), .nRESET(nRESET), .bus(if3.slave));

  assign if1.MISO = 1'b1;
  assign if2.MISO = if2.MOSI;
  assign if3.MISO = if3.MOSI;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  int busy1 = 0, mosihi1 = 0, done1 = 0;
  int busy2 = 0, rise2 = 0, done2 = 0;
  int busy3 = 0, done3 = 0, busy_after_done3 = 0;
  logic [7:0] seq2 = 8'h00;
  logic       sck2_q = 1'b0;
  logic       pend3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitors: pop the expected byte whenever a DUT pulses DONE.
  always @(negedge CLK) begin
    if (if1.BUSY) busy1++;
    if (if1.BUSY && if1.MOSI) mosihi1++;
    if (if1.DONE) begin
      done1++;
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL u1 unexpected DONE: got rxd 0x%0h, required no DONE", if1.RXD);
      end else check("u1 rxd", {24'h0, if1.RXD}, {24'h0, q1.pop_front()});
    end
  end

  always @(negedge CLK) begin
    if (if2.BUSY) busy2++;
    if (if2.SCK && !sck2_q) begin
      rise2++;
      seq2 = {seq2[6:0], if2.MOSI};
    end
    sck2_q = if2.SCK;
    if (if2.DONE) begin
      done2++;
      if (q2.size() == 0) begin
        n_checks++;
        $display("FAIL u2 unexpected DONE: got rxd 0x%0h, required no DONE", if2.RXD);
      end else check("u2 rxd", {24'h0, if2.RXD}, {24'h0, q2.pop_front()});
    end
  end

  always @(negedge CLK) begin
    if (if3.BUSY) busy3++;
    if (pend3 && if3.BUSY) busy_after_done3++;
    pend3 = if3.DONE;
    if (if3.DONE) begin
      done3++;
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL u3 unexpected DONE: got rxd 0x%0h, required no DONE", if3.RXD);
      end else check("u3 rxd", {24'h0, if3.RXD}, {24'h0, q3.pop_front()});
    end
  end

  // Single-cycle START; TXD is scrambled afterwards so a late sample would show.
  task automatic start(input int n, input logic [7:0] d);
    @(posedge CLK); #1;
    case (n)
      1: begin if1.START = 1'b1; if1.TXD = d; end
      2: begin if2.START = 1'b1; if2.TXD = d; end
      default: begin if3.START = 1'b1; if3.TXD = d; end
    endcase
    @(posedge CLK); #1;
    if1.START = 1'b0; if2.START = 1'b0; if3.START = 1'b0;
    if1.TXD = ~d; if2.TXD = ~d; if3.TXD = ~d;
  endtask

  int b0, r0, d0, m0, a0;

  initial begin
    if1.START = 1'b0; if1.TXD = 8'h00;
    if2.START = 1'b0; if2.TXD = 8'h00;
    if3.START = 1'b0; if3.TXD = 8'h00;

    repeat (3) @(posedge CLK);
    #1 nRESET = 1'b1;
    @(negedge CLK);
    check("reset sck",  {31'h0, if2.SCK},  32'h0);
    check("reset mosi", {31'h0, if2.MOSI}, 32'h0);
    check("reset busy", {31'h0, if2.BUSY}, 32'h0);
    check("reset done", {31'h0, if2.DONE}, 32'h0);
    check("reset rxd",  {24'h0, if2.RXD},  32'h0);

    // DIV=2 loopback 0xA5
    b0 = busy2; r0 = rise2; d0 = done2;
    q2.push_back(8'hA5);
    start(2, 8'hA5);
    repeat (40) @(negedge CLK);
    check("a5 busy cycles", busy2 - b0, 32);
    check("a5 sck rises",   rise2 - r0, 8);
    check("a5 done pulses", done2 - d0, 1);
    check("a5 mosi seq",    {24'h0, seq2}, 32'hA5);
    check("a5 mosi holds last bit", {31'h0, if2.MOSI}, 32'h1);

    // DIV=1, MISO=1, TXD=0x00
    b0 = busy1; m0 = mosihi1; d0 = done1;
    q1.push_back(8'hFF);
    start(1, 8'h00);
    repeat (25) @(negedge CLK);
    check("div1 busy cycles", busy1 - b0, 16);
    check("div1 mosi high cycles", mosihi1 - m0, 0);
    check("div1 done pulses", done1 - d0, 1);

    // DIV=2, 0x3C with an ignored 0xFF START mid-transfer
    r0 = rise2; d0 = done2;
    q2.push_back(8'h3C);
    start(2, 8'h3C);
    repeat (10) @(negedge CLK);
    start(2, 8'hFF);
    repeat (40) @(negedge CLK);
    check("3c mosi seq",    {24'h0, seq2}, 32'h3C);
    check("3c sck rises",   rise2 - r0, 8);
    check("3c done pulses", done2 - d0, 1);

    // DIV=3 back-to-back: 0x81 started in the DONE cycle of 0x55
    b0 = busy3; d0 = done3; a0 = busy_after_done3;
    q3.push_back(8'h55);
    q3.push_back(8'h81);
    start(3, 8'h55);
    for (int t = 0; t < 200 && !if3.DONE; t++) @(negedge CLK);
    check("b2b first done seen", {31'h0, if3.DONE}, 32'h1);
    if3.START = 1'b1; if3.TXD = 8'h81;
    @(posedge CLK); #1;
    if3.START = 1'b0; if3.TXD = 8'h00;
    repeat (60) @(negedge CLK);
    check("b2b busy cycles", busy3 - b0, 96);
    check("b2b done pulses", done3 - d0, 2);
    check("b2b busy right after first done", busy_after_done3 - a0, 1);

    // DIV=2 reset after the 4th SCK rise, then a clean 0x5A transfer
    r0 = rise2; d0 = done2;
    start(2, 8'h96);
    for (int t = 0; t < 100 && rise2 < r0 + 4; t++) @(negedge CLK);
    check("abort rises before reset", rise2 - r0, 4);
    #2 nRESET = 1'b0;
    #1;
    check("abort sck",  {31'h0, if2.SCK},  32'h0);
    check("abort busy", {31'h0, if2.BUSY}, 32'h0);
    check("abort rxd",  {24'h0, if2.RXD},  32'h0);
    check("abort mosi", {31'h0, if2.MOSI}, 32'h0);
    @(posedge CLK); @(posedge CLK);
    #1 nRESET = 1'b1;
    repeat (5) @(negedge CLK);
    check("abort no done", done2 - d0, 0);
    check("abort rxd stays zero", {24'h0, if2.RXD}, 32'h0);
    d0 = done2;
    q2.push_back(8'h5A);
    start(2, 8'h5A);
    repeat (40) @(negedge CLK);
    check("5a done pulses", done2 - d0, 1);
    check("5a rxd holds",   {24'h0, if2.RXD}, 32'h5A);

    check("u1 queue drained", q1.size(), 0);
    check("u2 queue drained", q2.size(), 0);
    check("u3 queue drained", q3.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
